// File: rtl/gate_pkg.sv
// gate_pkg
// Shared definitions for the gate sweep slice: operation codes, sweeper
// FSM encoding, the largest supported input count and a helper that turns
// an input count into a truth-table width.
// No ports; imported by gate_core, gate_sweep_unit_if and gate_sweep_unit.
package gate_pkg;

  localparam int MAX_N_IN = 4;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_BUF  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // One truth-table bit per input combination.
  function automatic int ttWidth(input int nIn);
    return 1 << nIn;
  endfunction

endpackage

// File: rtl/gate_sweep_unit_if.sv
// gate_sweep_unit_if
// Request/result bundle between a stimulus source (master) and the gate
// sweeper (slave).
//   start, op        master -> slave  sweep request and operation code
//   busy, done       slave -> master  sweep in progress / completion pulse
//   vec, s           slave -> master  applied input combination, live output
//   truth            slave -> master  captured truth table
// With GATE_CHECK_EN defined two more signals exist:
//   expect_tt        master -> slave  reference truth table
//   match            slave -> master  registered truth == expect_tt
// The reference is called expect_tt because "expect" is a reserved word.
interface gate_sweep_unit_if #(parameter int N_IN = 2);
  import gate_pkg::*;

  localparam int TT_W = ttWidth(N_IN);

  logic              start;
  logic [2:0]        op;
  logic              busy;
  logic              done;
  logic [N_IN-1:0]   vec;
  logic              s;
  logic [TT_W-1:0]   truth;
`ifdef GATE_CHECK_EN
  logic [TT_W-1:0]   expect_tt;
  logic              match;

  modport master (output start, op, expect_tt,
                  input  busy, done, vec, s, truth, match);
  modport slave  (input  start, op, expect_tt,
                  output busy, done, vec, s, truth, match);
`else
  modport master (output start, op,
                  input  busy, done, vec, s, truth);
  modport slave  (input  start, op,
                  output busy, done, vec, s, truth);
`endif

endinterface

// File: rtl/gate_core.sv
// gate_core
// Purely combinational N-input gate selectable by a 3-bit operation code.
// Reusable on its own, independent of the sweeper.
//   op   in  3     operation code (gate_pkg OP_*)
//   vec  in  N_IN  gate inputs
//   s    out 1     gate output
// AND..XNOR reduce over every bit of vec; NOT and BUF look at vec[0] only.
module gate_core
  import gate_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [2:0]      op,
  input  logic [N_IN-1:0] vec,
  output logic            s
);

  // Select the requested reduction of the input vector.
  always_comb begin
    s = 1'b0;
    case (op)
      OP_AND:  s = &vec;
      OP_OR:   s = |vec;
      OP_NAND: s = ~&vec;
      OP_NOR:  s = ~|vec;
      OP_XOR:  s = ^vec;
      OP_XNOR: s = ~^vec;
      OP_NOT:  s = ~vec[0];
      OP_BUF:  s = vec[0];
      default: s = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_sweep_unit.sv
// gate_sweep_unit
// Truth-table generator: on an accepted start it latches op, walks vec
// through every input combination one per clock, records the gate output
// of each into truth and raises done for one cycle.
//   clk    in  1  rising-edge clock
//   rst_n  in  1  synchronous active-low reset
//   bus    slave modport of gate_sweep_unit_if (start, op, busy, done,
//                 vec, s, truth, plus expect_tt/match when enabled)
// Optional feature macro: GATE_CHECK_EN adds a registered comparison of
// the finished truth table against expect_tt.
module gate_sweep_unit
  import gate_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  gate_sweep_unit_if.slave bus
);

  localparam int TT_W = ttWidth(N_IN);
  localparam logic [N_IN-1:0] VEC_LAST = '1;
  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);

  generate
    if (N_IN < 1 || N_IN > MAX_N_IN) begin : g_badNIn
      $error("gate_sweep_unit: N_IN=%0d is outside 1..%0d", N_IN, MAX_N_IN);
    end
  endgenerate

  state_t          r_state;
  logic            r_busy;
  logic            r_done;
  logic [2:0]      r_op;
  logic [N_IN-1:0] r_vec;
  logic [TT_W-1:0] r_truth;
  logic            w_s;
  logic [TT_W-1:0] w_truthNext;
`ifdef GATE_CHECK_EN
  logic            r_match;
`endif

  gate_core #(
    .N_IN (N_IN)
  ) u_core (
    .op  (r_op),
    .vec (r_vec),
    .s   (w_s)
  );

  // Truth table as it will look after the current sweep edge; also the
  // value compared at DONE entry so the last bit is included.
  always_comb begin
    w_truthNext        = r_truth;
    w_truthNext[r_vec] = w_s;
  end

  // Sweeper FSM. Every output is a register updated here; done defaults
  // low so it can only ever be a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_op    <= OP_AND;
      r_vec   <= '0;
      r_truth <= '0;
`ifdef GATE_CHECK_EN
      r_match <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state <= ST_SWEEP;
            r_busy  <= 1'b1;
            r_op    <= bus.op;
            r_vec   <= '0;
            r_truth <= '0;
`ifdef GATE_CHECK_EN
            r_match <= 1'b0;
`endif
          end
        end
        ST_SWEEP: begin
          r_truth <= w_truthNext;
          if (r_vec != VEC_LAST) begin
            r_vec <= r_vec + VEC_ONE;
          end else begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
`ifdef GATE_CHECK_EN
            r_match <= (w_truthNext == bus.expect_tt);
`endif
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.vec   = r_vec;
  assign bus.s     = w_s;
  assign bus.truth = r_truth;
`ifdef GATE_CHECK_EN
  assign bus.match = r_match;
`endif

endmodule

// File: tb/tb_gate_sweep_unit.sv
// tb_gate_sweep_unit
// Drives two sweepers (N_IN=2 and N_IN=3) from one clock. Each issued sweep
// pushes its predicted truth table (and match, with GATE_CHECK_EN) into a
// per-instance queue; a monitor pops and compares on every done pulse.
module tb_gate_sweep_unit;
  import gate_pkg::*;

  typedef struct {
    logic [15:0] truth;
    logic        match;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        drvStart [2];
  logic [2:0]  drvOp    [2];
  logic [15:0] drvExp   [2];
  int          total = 0;
  int          bad   = 0;
  exp_t        sbq0[$];
  exp_t        sbq1[$];

  gate_sweep_unit_if #(.N_IN(2)) if2 ();
  gate_sweep_unit_if #(.N_IN(3)) if3 ();

  gate_sweep_unit #(.N_IN(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  gate_sweep_unit #(.N_IN(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  assign if2.start = drvStart[0];
  assign if2.op    = drvOp[0];
  assign if3.start = drvStart[1];
  assign if3.op    = drvOp[1];

  logic [1:0]  obsBusy, obsDone, obsS;
  logic [3:0]  obsVec   [2];
  logic [15:0] obsTruth [2];
  assign obsBusy     = {if3.busy, if2.busy};
  assign obsDone     = {if3.done, if2.done};
  assign obsS        = {if3.s, if2.s};
  assign obsVec[0]   = 4'(if2.vec);
  assign obsVec[1]   = 4'(if3.vec);
  assign obsTruth[0] = 16'(if2.truth);
  assign obsTruth[1] = 16'(if3.truth);
`ifdef GATE_CHECK_EN
  logic [1:0] obsMatch;
  assign if2.expect_tt = drvExp[0][3:0];
  assign if3.expect_tt = drvExp[1][7:0];
  assign obsMatch      = {if3.match, if2.match};
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: each truth bit follows from the number of ones in its index.
  function automatic logic [15:0] refTruth(input logic [2:0] opv, input int nIn);
    logic [15:0] t;
    int ones;
    bit allOne, anyOne, odd, lsb;
    t = '0;
    for (int i = 0; i < (1 << nIn); i++) begin
      ones   = $countones(i);
      allOne = (ones == nIn);
      anyOne = (ones > 0);
      odd    = (ones % 2) == 1;
      lsb    = (i % 2) == 1;
      case (opv)
        3'd0: t[i] = allOne;
        3'd1: t[i] = anyOne;
        3'd2: t[i] = !allOne;
        3'd3: t[i] = !anyOne;
        3'd4: t[i] = odd;
        3'd5: t[i] = !odd;
        3'd6: t[i] = !lsb;
        default: t[i] = lsb;
      endcase
    end
    return t;
  endfunction

  task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic pushExp(input int sel, input logic [2:0] opv, input logic [15:0] expv);
    exp_t e;
    e.truth = refTruth(opv, sel + 2);
    e.match = (e.truth == expv);
    if (sel == 0) sbq0.push_back(e);
    else          sbq1.push_back(e);
  endtask

  // Monitor side: pop the oldest prediction on each done pulse.
  task automatic checkOutput(input int sel);
    exp_t e;
    int   sz;
    sz = (sel == 0) ? sbq0.size() : sbq1.size();
    if (sz == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL unexpectedDone dut%0d: got done=1 expected no pulse", sel);
      return;
    end
    if (sel == 0) e = sbq0.pop_front();
    else          e = sbq1.pop_front();
    compareVal($sformatf("truth dut%0d", sel), 32'(obsTruth[sel]), 32'(e.truth));
    compareVal($sformatf("busyAtDone dut%0d", sel), 32'(obsBusy[sel]), 32'd0);
`ifdef GATE_CHECK_EN
    compareVal($sformatf("match dut%0d", sel), 32'(obsMatch[sel]), 32'(e.match));
`endif
  endtask

  always @(negedge clk) begin
    if (obsDone[0]) checkOutput(0);
    if (obsDone[1]) checkOutput(1);
  end

  task automatic waitIdle(input int sel);
    int n;
    n = 0;
    @(negedge clk);
    while ((obsBusy[sel] || obsDone[sel]) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      total++;
      bad++;
      $display("[TB] FAIL idleTimeout dut%0d: got busy after %0d cycles expected idle", sel, n);
    end
  endtask

  // One sweep; optionally disturbs op and start while the sweep runs.
  task automatic applyStimulus(input int sel, input logic [2:0] opv,
                               input bit disturb, input logic [15:0] expv);
    int tt, k, doneAt, doneCnt, busyCnt;
    tt = 1 << (sel + 2);
    waitIdle(sel);
    drvOp[sel]    = opv;
    drvExp[sel]   = expv;
    drvStart[sel] = 1'b1;
    pushExp(sel, opv, expv);
    @(negedge clk);
    drvStart[sel] = 1'b0;
`ifdef GATE_CHECK_EN
    compareVal($sformatf("matchCleared dut%0d", sel), 32'(obsMatch[sel]), 32'd0);
`endif
    doneAt = 0; doneCnt = 0; busyCnt = 0;
    for (k = 1; k <= tt + 3; k++) begin
      if (obsBusy[sel]) busyCnt++;
      if (obsDone[sel]) begin
        doneCnt++;
        if (doneAt == 0) doneAt = k;
      end
      if (disturb && k == 2) begin
        drvOp[sel]    = opv ^ 3'b001;
        drvStart[sel] = 1'b1;
      end
      if (disturb && k == 3) drvStart[sel] = 1'b0;
      @(negedge clk);
    end
    compareVal($sformatf("doneLatency dut%0d", sel), 32'(doneAt), 32'(tt + 1));
    compareVal($sformatf("busyCycles dut%0d", sel), 32'(busyCnt), 32'(tt));
    compareVal($sformatf("doneCount dut%0d", sel), 32'(doneCnt), 32'd1);
  endtask

  // Start held high across two sweeps; op switches once the first is latched.
  task automatic backToBack(input int sel, input logic [2:0] op1, input logic [2:0] op2);
    int tt, d1, d2;
    tt = 1 << (sel + 2);
    waitIdle(sel);
    drvOp[sel]    = op1;
    drvStart[sel] = 1'b1;
    pushExp(sel, op1, drvExp[sel]);
    pushExp(sel, op2, drvExp[sel]);
    @(negedge clk);
    d1 = 0; d2 = 0;
    for (int k = 1; k <= 2 * tt + 5; k++) begin
      if (obsDone[sel]) begin
        if (d1 == 0) d1 = k;
        else if (d2 == 0) d2 = k;
      end
      if (k == 1) drvOp[sel] = op2;
      if (k == tt + 3) drvStart[sel] = 1'b0;
      @(negedge clk);
    end
    compareVal("b2bFirstDone", 32'(d1), 32'(tt + 1));
    compareVal("b2bPeriod", 32'(d2 - d1), 32'(tt + 2));
  endtask

  // Reset pulse in the third sweep cycle must abort without a done pulse.
  task automatic resetAbort(input int sel, input logic [2:0] opv);
    waitIdle(sel);
    drvOp[sel]    = opv;
    drvStart[sel] = 1'b1;
    @(negedge clk);
    drvStart[sel] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    compareVal("abortBusy", 32'(obsBusy[sel]), 32'd0);
    compareVal("abortDone", 32'(obsDone[sel]), 32'd0);
    compareVal("abortVec", 32'(obsVec[sel]), 32'd0);
    compareVal("abortTruth", 32'(obsTruth[sel]), 32'd0);
    compareVal("abortS", 32'(obsS[sel]), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [2:0]  opv;
    logic [15:0] expv;
    for (int s = 0; s < 2; s++) begin
      drvStart[s] = 1'b0;
      drvOp[s]    = 3'd0;
      drvExp[s]   = '0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      compareVal($sformatf("rstBusy dut%0d", s), 32'(obsBusy[s]), 32'd0);
      compareVal($sformatf("rstDone dut%0d", s), 32'(obsDone[s]), 32'd0);
      compareVal($sformatf("rstVec dut%0d", s), 32'(obsVec[s]), 32'd0);
      compareVal($sformatf("rstTruth dut%0d", s), 32'(obsTruth[s]), 32'd0);
      compareVal($sformatf("rstS dut%0d", s), 32'(obsS[s]), 32'd0);
    end
    rst_n = 1'b1;

    $display("[TB] directed sweeps on N_IN=2");
    applyStimulus(0, OP_NAND, 1'b0, 16'h0007);
    applyStimulus(0, OP_NAND, 1'b0, 16'h000E);
    backToBack(0, OP_XOR, OP_XNOR);
    applyStimulus(0, OP_OR, 1'b1, 16'h0000);
    resetAbort(0, OP_XOR);
    applyStimulus(0, OP_NOT, 1'b0, 16'h0005);

    $display("[TB] directed sweeps on N_IN=3");
    applyStimulus(1, OP_AND, 1'b0, 16'h0080);
    applyStimulus(1, OP_NOR, 1'b0, 16'h0000);

    $display("[TB] random sweeps");
    for (int r = 0; r < 16; r++) begin
      int sel;
      sel  = r % 2;
      opv  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) expv = refTruth(opv, sel + 2);
      else expv = 16'($urandom) & ((sel == 0) ? 16'h000F : 16'h00FF);
      applyStimulus(sel, opv, $urandom_range(0, 1) == 1, expv);
    end

    repeat (4) @(negedge clk);
    compareVal("leftover dut0", 32'(sbq0.size()), 32'd0);
    compareVal("leftover dut1", 32'(sbq1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
